// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: memory bridge states and default bus widths
package cpu_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } bridge_state_t;

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - saturating wait-state counter with terminal flag
module wait_timer #(
    parameter int TIMEOUT = 15,
    parameter int TMR_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic terminal
);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_inc;

    assign count_inc = count_q + TMR_W'(1);

    // Flags the enabled cycle whose increment brings the count to TIMEOUT.
    assign terminal = en && (count_inc == TMR_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (en && (count_q != TMR_W'(TIMEOUT))) begin
            count_q <= count_inc;
        end
    end

endmodule

// File: rtl/cpu_mem_bridge.sv
// rtl/cpu_mem_bridge.sv - req/ack memory port between the CPU core and external memory
module cpu_mem_bridge
    import cpu_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic              core_read,
    input  logic              core_write,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    output logic              core_stall,
    output logic              core_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    bridge_state_t state, state_next;
    logic          core_req;
    logic          accept;
    logic          tmr_term;
    logic          in_busy;

    assign core_req = core_read | core_write;
    assign in_busy  = (state == BUSY);

    wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (!in_busy),
        .en       (in_busy),
        .terminal (tmr_term)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        core_stall = 1'b0;
        case (state)
            IDLE, RESP: begin
                core_stall = core_req;
                if (core_req) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                core_stall = 1'b1;
                // A completing ack on the final allowed cycle beats the timeout.
                if (mem_ack) begin
                    state_next = RESP;
                end else if (tmr_term) begin
                    state_next = ERR;
                end
            end
            ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req     <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            core_rdata  <= '0;
            core_rvalid <= 1'b0;
            core_err    <= 1'b0;
        end else begin
            mem_req     <= (state_next == BUSY);
            core_rvalid <= in_busy && mem_ack && !mem_write;
            core_err    <= in_busy && !mem_ack && tmr_term;
            // Write wins when both are requested; the read is silently dropped.
            if (accept) begin
                mem_addr  <= core_addr;
                mem_wdata <= core_wdata;
                mem_write <= core_write;
            end
            if (in_busy && mem_ack && !mem_write) begin
                core_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// tb/tb_cpu_mem_bridge.sv - directed table-driven bench for cpu_mem_bridge
module tb_cpu_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;

    logic [7:0]  core_addr, core_wdata, core_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        core_read, core_write, core_rvalid, core_stall, core_err;
    logic        mem_write, mem_req, mem_ack;

    logic [11:0] b_core_addr, b_mem_addr;
    logic [15:0] b_core_wdata, b_core_rdata, b_mem_wdata, b_mem_rdata;
    logic        b_core_read, b_core_write, b_core_rvalid, b_core_stall, b_core_err;
    logic        b_mem_write, b_mem_req, b_mem_ack;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_rdata;

    always #5 clk = ~clk;

    cpu_mem_bridge u_dut (
        .clk (clk), .reset (reset),
        .core_addr (core_addr), .core_wdata (core_wdata),
        .core_read (core_read), .core_write (core_write),
        .core_rdata (core_rdata), .core_rvalid (core_rvalid),
        .core_stall (core_stall), .core_err (core_err),
        .mem_addr (mem_addr), .mem_wdata (mem_wdata),
        .mem_write (mem_write), .mem_req (mem_req),
        .mem_ack (mem_ack), .mem_rdata (mem_rdata)
    );

    cpu_mem_bridge #(.DATA_W(16), .ADDR_W(12), .TIMEOUT(15)) u_dut_wide (
        .clk (clk), .reset (reset),
        .core_addr (b_core_addr), .core_wdata (b_core_wdata),
        .core_read (b_core_read), .core_write (b_core_write),
        .core_rdata (b_core_rdata), .core_rvalid (b_core_rvalid),
        .core_stall (b_core_stall), .core_err (b_core_err),
        .mem_addr (b_mem_addr), .mem_wdata (b_mem_wdata),
        .mem_write (b_mem_write), .mem_req (b_mem_req),
        .mem_ack (b_mem_ack), .mem_rdata (b_mem_rdata)
    );

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         waits;
        logic [7:0] rdata;
        logic       exp_write;
        logic       exp_rvalid;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_access(input vec_t v);
        core_read  = v.rd;
        core_write = v.wr;
        core_addr  = v.addr;
        core_wdata = v.wdata;
        #1 chk("stall_on_request", core_stall, 1);
        for (int w = 0; w <= v.waits; w++) begin
            @(negedge clk);
            chk("mem_req_busy", mem_req, 1);
            chk("mem_addr_stable", mem_addr, v.addr);
            chk("mem_write_op", mem_write, v.exp_write);
            if (v.exp_write) chk("mem_wdata_stable", mem_wdata, v.wdata);
            chk("stall_busy", core_stall, 1);
            if (w == v.waits) begin
                mem_ack   = 1'b1;
                mem_rdata = v.rdata;
            end
        end
        @(negedge clk);
        mem_ack    = 1'b0;
        mem_rdata  = 8'hEE;
        core_read  = 1'b0;
        core_write = 1'b0;
        #1;
        chk("mem_req_drop", mem_req, 0);
        chk("rvalid_resp", core_rvalid, v.exp_rvalid);
        if (v.exp_rvalid) last_rdata = v.rdata;
        chk("rdata_resp", core_rdata, last_rdata);
        chk("stall_resp", core_stall, 0);
        chk("err_resp", core_err, 0);
        @(negedge clk);
        chk("rvalid_pulse_end", core_rvalid, 0);
    endtask

    initial begin
        reset = 1'b1;
        core_addr = '0; core_wdata = '0; core_read = 1'b0; core_write = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        b_core_addr = '0; b_core_wdata = '0; b_core_read = 1'b0; b_core_write = 1'b0;
        b_mem_ack = 1'b0; b_mem_rdata = '0;
        last_rdata = 8'h00;

        vecs[0] = '{rd:1, wr:0, addr:8'h3C, wdata:8'h00, waits:0,  rdata:8'hA5, exp_write:0, exp_rvalid:1};
        vecs[1] = '{rd:0, wr:1, addr:8'h10, wdata:8'h5A, waits:3,  rdata:8'h99, exp_write:1, exp_rvalid:0};
        vecs[2] = '{rd:1, wr:1, addr:8'h20, wdata:8'h77, waits:1,  rdata:8'h66, exp_write:1, exp_rvalid:0};
        vecs[3] = '{rd:1, wr:0, addr:8'hFF, wdata:8'h00, waits:2,  rdata:8'h00, exp_write:0, exp_rvalid:1};
        vecs[4] = '{rd:1, wr:0, addr:8'h01, wdata:8'h00, waits:14, rdata:8'h3C, exp_write:0, exp_rvalid:1};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_mem_req", mem_req, 0);
        chk("reset_rvalid", core_rvalid, 0);
        chk("reset_err", core_err, 0);
        chk("reset_rdata", core_rdata, 0);
        chk("reset_stall", core_stall, 0);

        for (int i = 0; i < 5; i++) do_access(vecs[i]);

        // Stray ack while idle must have no effect.
        mem_ack = 1'b1; mem_rdata = 8'h42;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_ack_req", mem_req, 0);
        chk("stray_ack_rvalid", core_rvalid, 0);
        chk("stray_ack_rdata", core_rdata, last_rdata);

        // Timeout: never ack.
        core_read = 1'b1; core_addr = 8'h44;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            chk("timeout_req_high", mem_req, 1);
            chk("timeout_no_err", core_err, 0);
        end
        @(negedge clk);
        core_read = 1'b0;
        #1;
        chk("timeout_req_low", mem_req, 0);
        chk("timeout_err", core_err, 1);
        chk("timeout_stall", core_stall, 0);
        chk("timeout_rvalid", core_rvalid, 0);
        chk("timeout_rdata", core_rdata, last_rdata);
        @(negedge clk);
        chk("timeout_err_pulse", core_err, 0);
        chk("timeout_idle_req", mem_req, 0);

        // Back-to-back: second read presented in the RESP cycle.
        core_read = 1'b1; core_addr = 8'h30;
        @(negedge clk);
        chk("b2b_req1", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 8'h11;
        @(negedge clk);
        mem_ack = 1'b0; core_addr = 8'h31;
        #1;
        chk("b2b_rvalid1", core_rvalid, 1);
        chk("b2b_rdata1", core_rdata, 8'h11);
        chk("b2b_stall_resp", core_stall, 1);
        @(negedge clk);
        chk("b2b_req2", mem_req, 1);
        chk("b2b_addr2", mem_addr, 8'h31);
        chk("b2b_rvalid_gap", core_rvalid, 0);
        mem_ack = 1'b1; mem_rdata = 8'h22;
        @(negedge clk);
        mem_ack = 1'b0; core_read = 1'b0;
        #1;
        chk("b2b_rvalid2", core_rvalid, 1);
        chk("b2b_rdata2", core_rdata, 8'h22);
        chk("b2b_stall_end", core_stall, 0);
        @(negedge clk);

        // Reset in the middle of an access; a late ack is ignored.
        core_read = 1'b1; core_addr = 8'h55;
        @(negedge clk);
        chk("rst_mid_req", mem_req, 1);
        reset = 1'b1; core_read = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_req_low", mem_req, 0);
        chk("rst_mid_write", mem_write, 0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_wdata", mem_wdata, 0);
        chk("rst_mid_rdata", core_rdata, 0);
        chk("rst_mid_rvalid", core_rvalid, 0);
        chk("rst_mid_err", core_err, 0);
        mem_ack = 1'b1; mem_rdata = 8'hC3;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_rvalid", core_rvalid, 0);
        chk("late_ack_rdata", core_rdata, 0);
        chk("late_ack_req", mem_req, 0);

        // Wide instance: zero-wait read.
        b_core_read = 1'b1; b_core_addr = 12'hABC;
        #1 chk("wide_stall_req", b_core_stall, 1);
        @(negedge clk);
        chk("wide_mem_req", b_mem_req, 1);
        chk("wide_mem_addr", b_mem_addr, 12'hABC);
        chk("wide_mem_write", b_mem_write, 0);
        b_mem_ack = 1'b1; b_mem_rdata = 16'hBEEF;
        @(negedge clk);
        b_mem_ack = 1'b0; b_core_read = 1'b0;
        #1;
        chk("wide_rvalid", b_core_rvalid, 1);
        chk("wide_rdata", b_core_rdata, 16'hBEEF);
        chk("wide_stall_end", b_core_stall, 0);
        chk("wide_req_drop", b_mem_req, 0);
        @(negedge clk);
        chk("wide_rvalid_end", b_core_rvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
